// File: rtl/vga_timing_if.sv
// Video timing bundle: pixel position, sync/blank strobes and frame markers.
interface vga_timing_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing.sv
// VGA raster timing generator, all outputs registered and aligned to one pixel.
// Optional frames-completed counter enabled by macro VGA_FRAME_CNT_EN.
module vga_timing #(
    parameter int HL_TOTAL  = 1344,
    parameter int HL_BLANK  = 1024,
    parameter int HL_SYNC_S = 1048,
    parameter int HL_SYNC_E = 1184,
    parameter int VL_TOTAL  = 806,
    parameter int VL_BLANK  = 768,
    parameter int VL_SYNC_S = 771,
    parameter int VL_SYNC_E = 777
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam logic [10:0] H_LAST   = 11'(HL_TOTAL - 1);
    localparam logic [10:0] H_BLANK  = 11'(HL_BLANK);
    localparam logic [10:0] H_SYNC_S = 11'(HL_SYNC_S);
    localparam logic [10:0] H_SYNC_E = 11'(HL_SYNC_E);
    localparam logic [10:0] V_LAST   = 11'(VL_TOTAL - 1);
    localparam logic [10:0] V_BLANK  = 11'(VL_BLANK);
    localparam logic [10:0] V_SYNC_S = 11'(VL_SYNC_S);
    localparam logic [10:0] V_SYNC_E = 11'(VL_SYNC_E);

    logic [10:0] hcount_r;
    logic [10:0] vcount_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        hblnk_r;
    logic        vblnk_r;
    logic        frame_start_r;

    logic [10:0] h_nxt_s;
    logic [10:0] v_nxt_s;
    logic        h_wrap_s;
    logic        fs_nxt_s;

    // Next pixel position; ">=" comparisons also recover out-of-range counts.
    always_comb begin
        h_wrap_s = (hcount_r >= H_LAST);
        h_nxt_s  = h_wrap_s ? 11'd0 : (hcount_r + 11'd1);
        v_nxt_s  = vcount_r;
        if (h_wrap_s) begin
            v_nxt_s = (vcount_r >= V_LAST) ? 11'd0 : (vcount_r + 11'd1);
        end else if (vcount_r > V_LAST) begin
            v_nxt_s = 11'd0;
        end else begin
            v_nxt_s = vcount_r;
        end
        fs_nxt_s = (h_nxt_s == 11'd0) && (v_nxt_s == 11'd0);
    end

    // Counters and strobes all decoded from the next position so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_r      <= 11'd0;
            vcount_r      <= 11'd0;
            hsync_r       <= 1'b0;
            vsync_r       <= 1'b0;
            hblnk_r       <= 1'b0;
            vblnk_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            hcount_r      <= h_nxt_s;
            vcount_r      <= v_nxt_s;
            hblnk_r       <= (h_nxt_s >= H_BLANK);
            hsync_r       <= (h_nxt_s >= H_SYNC_S) && (h_nxt_s < H_SYNC_E);
            vblnk_r       <= (v_nxt_s >= V_BLANK);
            vsync_r       <= (v_nxt_s >= V_SYNC_S) && (v_nxt_s < V_SYNC_E);
            frame_start_r <= fs_nxt_s;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frames-completed count, bumped on the same edge that raises frame_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= 16'd0;
        end else if (fs_nxt_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign vga.frame_cnt = frame_cnt_r;
`else
    assign vga.frame_cnt = 16'd0;
`endif

    assign vga.hcount      = hcount_r;
    assign vga.vcount      = vcount_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.hblnk       = hblnk_r;
    assign vga.vblnk       = vblnk_r;
    assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-size timing for line edges, a shrunken raster for frame edges.
module tb_vga_timing;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if d_if ();
    vga_timing_if s_if ();

    vga_timing u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (d_if.master)
    );

    vga_timing #(
        .HL_TOTAL (16), .HL_BLANK (10), .HL_SYNC_S (11), .HL_SYNC_E (13),
        .VL_TOTAL (8),  .VL_BLANK (5),  .VL_SYNC_S (6),  .VL_SYNC_E (7)
    ) u_small (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (s_if.master)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int d_h, d_v, s_h, s_v, s_fcnt, d_fcnt;
    bit d_fs, s_fs, in_rst;
    int rel_cyc, last_fs, fs_pulses;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        d_h = 0; d_v = 0; d_fs = 1'b0; d_fcnt = 0;
        s_h = 0; s_v = 0; s_fs = 1'b0; s_fcnt = 0;
    endtask

    // Reference raster advance with hand-coded totals for both instances.
    task automatic model_step();
        if (d_h == 1343) begin
            d_h = 0;
            d_v = (d_v == 805) ? 0 : d_v + 1;
        end else begin
            d_h = d_h + 1;
        end
        d_fs = (d_h == 0) && (d_v == 0);
        if (d_fs) d_fcnt = (d_fcnt + 1) % 65536;
        if (s_h == 15) begin
            s_h = 0;
            s_v = (s_v == 7) ? 0 : s_v + 1;
        end else begin
            s_h = s_h + 1;
        end
        s_fs = (s_h == 0) && (s_v == 0);
        if (s_fs) s_fcnt = (s_fcnt + 1) % 65536;
    endtask

    task automatic compare_all();
        int dfc, sfc;
`ifdef VGA_FRAME_CNT_EN
        dfc = d_fcnt; sfc = s_fcnt;
`else
        dfc = 0; sfc = 0;
`endif
        check("d_hcount", d_if.hcount, d_h);
        check("d_vcount", d_if.vcount, d_v);
        check("d_hblnk",  d_if.hblnk,  !in_rst && d_h >= 1024);
        check("d_hsync",  d_if.hsync,  !in_rst && d_h >= 1048 && d_h < 1184);
        check("d_vblnk",  d_if.vblnk,  !in_rst && d_v >= 768);
        check("d_vsync",  d_if.vsync,  !in_rst && d_v >= 771 && d_v < 777);
        check("d_fstart", d_if.frame_start, d_fs);
        check("d_fcnt",   d_if.frame_cnt, dfc);
        check("s_hcount", s_if.hcount, s_h);
        check("s_vcount", s_if.vcount, s_v);
        check("s_hblnk",  s_if.hblnk,  !in_rst && s_h >= 10);
        check("s_hsync",  s_if.hsync,  !in_rst && s_h >= 11 && s_h < 13);
        check("s_vblnk",  s_if.vblnk,  !in_rst && s_v >= 5);
        check("s_vsync",  s_if.vsync,  !in_rst && s_v == 6);
        check("s_fstart", s_if.frame_start, s_fs);
        check("s_fcnt",   s_if.frame_cnt, sfc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (!in_rst) model_step();
        @(negedge clk);
        compare_all();
        if (!in_rst && s_if.frame_start) begin
            if (last_fs < 0) check("s_first_fs", cyc - rel_cyc, 128);
            else             check("s_period",   cyc - last_fs, 128);
            last_fs = cyc;
            fs_pulses++;
        end
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        in_rst = 1'b0;
        rel_cyc = cyc;
        last_fs = -1;
        fs_pulses = 0;
    endtask

    initial begin
        int waited;
        in_rst = 1'b1;
        model_reset();
        rst_n = 1'b0;
        repeat (5) tick();

        @(negedge clk);
        release_reset();
        tick();
        check("rst_first_h", d_if.hcount, 1);
        check("rst_first_v", d_if.vcount, 0);
        repeat (2699) tick();
        check("s_fs_pulses", fs_pulses, 21);

        // Move the small raster to mid-frame, then reset between edges.
        waited = 0;
        while (!(s_h == 7 && s_v == 3) && waited < 200) begin
            tick();
            waited++;
        end
        check("mid_wait", waited < 200, 1);
        @(posedge clk);
        cyc++;
        model_step();
        #2;
        rst_n = 1'b0;
        in_rst = 1'b1;
        model_reset();
        #1;
        compare_all();
        repeat (3) tick();

        release_reset();
        tick();
        check("mid_restart_h", s_if.hcount, 1);
        check("mid_restart_v", s_if.vcount, 0);
        repeat (299) tick();
        check("mid_fs_pulses", fs_pulses, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
